// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scanner for the 4-digit common-anode
// 7-segment display. Drives one digit per slot into the downstream decoder,
// with frame-synchronous value loading, per-digit enable/blink and an
// anti-ghosting dead time at the start of every slot.
module seg_scan_mux #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_digit_en,
  input  logic [3:0]  i_blink,
  output logic [3:0]  o_binary,
  output logic        o_en,
  output logic [3:0]  o_anode,
  output logic        o_pending
);

  localparam int unsigned SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  // Scan position
  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [FW-1:0] frame_cnt, frame_nxt;
  logic          blink_phase, phase_nxt;

  // Displayed (active) and staged (shadow) settings
  logic [15:0]   act_value, act_value_nxt;
  logic [3:0]    act_en, act_en_nxt;
  logic [3:0]    act_blink, act_blink_nxt;
  logic [15:0]   shd_value, shd_value_nxt;
  logic [3:0]    shd_en, shd_en_nxt;
  logic [3:0]    shd_blink, shd_blink_nxt;
  logic          pending_nxt;

  // Output decode of the next state
  logic          slot_wrap;
  logic          frame_edge;
  logic          digit_on;
  logic          in_window;
  logic          visible;
  logic [3:0]    nibble_nxt;
  logic [3:0]    anode_nxt;

  // Next-state computation for counters, load handshake and output decode.
  // Outputs are decoded from the next state so the registered outputs line up
  // with the registered state without an extra cycle of latency.
  always_comb begin
    slot_wrap  = (slot_cnt == SLOT_LAST);
    frame_edge = slot_wrap && (idx == 2'd3);

    slot_nxt  = slot_wrap ? '0 : slot_cnt + SW'(1);
    idx_nxt   = slot_wrap ? idx + 2'd1 : idx;

    frame_nxt = frame_cnt;
    phase_nxt = blink_phase;
    if (frame_edge) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_nxt = '0;
        phase_nxt = ~blink_phase;
      end else begin
        frame_nxt = frame_cnt + FW'(1);
      end
    end

    shd_value_nxt = shd_value;
    shd_en_nxt    = shd_en;
    shd_blink_nxt = shd_blink;
    if (i_load) begin
      shd_value_nxt = i_value;
      shd_en_nxt    = i_digit_en;
      shd_blink_nxt = i_blink;
    end

    // Commit from the post-capture shadow so a load landing on the boundary
    // edge is applied immediately and never shows up as pending.
    act_value_nxt = act_value;
    act_en_nxt    = act_en;
    act_blink_nxt = act_blink;
    pending_nxt   = o_pending;
    if (frame_edge) begin
      if (i_load || o_pending) begin
        act_value_nxt = shd_value_nxt;
        act_en_nxt    = shd_en_nxt;
        act_blink_nxt = shd_blink_nxt;
      end
      pending_nxt = 1'b0;
    end else if (i_load) begin
      pending_nxt = 1'b1;
    end

    digit_on  = act_en_nxt[idx_nxt] & ~(act_blink_nxt[idx_nxt] & phase_nxt);
    in_window = (slot_nxt >= BLANK_END);
    visible   = digit_on & in_window;

    case (idx_nxt)
      2'd0:    nibble_nxt = act_value_nxt[3:0];
      2'd1:    nibble_nxt = act_value_nxt[7:4];
      2'd2:    nibble_nxt = act_value_nxt[11:8];
      default: nibble_nxt = act_value_nxt[15:12];
    endcase

    anode_nxt = visible ? ~(4'b0001 << idx_nxt) : '1;
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_cnt    <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      act_value   <= '0;
      act_en      <= '0;
      act_blink   <= '0;
      shd_value   <= '0;
      shd_en      <= '0;
      shd_blink   <= '0;
      o_pending   <= 1'b0;
      o_binary    <= '0;
      o_en        <= 1'b0;
      o_anode     <= '1;
    end else begin
      slot_cnt    <= slot_nxt;
      idx         <= idx_nxt;
      frame_cnt   <= frame_nxt;
      blink_phase <= phase_nxt;
      act_value   <= act_value_nxt;
      act_en      <= act_en_nxt;
      act_blink   <= act_blink_nxt;
      shd_value   <= shd_value_nxt;
      shd_en      <= shd_en_nxt;
      shd_blink   <= shd_blink_nxt;
      o_pending   <= pending_nxt;
      o_binary    <= nibble_nxt;
      o_en        <= visible;
      o_anode     <= anode_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scenarios plus random loads, every cycle
// compared against an edge-count based model of the display.
module tb_seg_scan_mux;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 4 * RD;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_load = 1'b0;
  logic [15:0] i_value = '0;
  logic [3:0]  i_digit_en = '0;
  logic [3:0]  i_blink = '0;
  logic [3:0]  o_binary;
  logic        o_en;
  logic [3:0]  o_anode;
  logic        o_pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: edges since reset, staged/active settings, pending flag
  int          m_n = 0;
  logic [15:0] m_shd_val = '0, m_act_val = '0;
  logic [3:0]  m_shd_en = '0, m_act_en = '0;
  logic [3:0]  m_shd_blk = '0, m_act_blk = '0;
  logic        m_pend = 1'b0;

  seg_scan_mux #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (i_load),
    .i_value   (i_value),
    .i_digit_en(i_digit_en),
    .i_blink   (i_blink),
    .o_binary  (o_binary),
    .o_en      (o_en),
    .o_anode   (o_anode),
    .o_pending (o_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, m_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0;
    m_shd_val = '0; m_shd_en = '0; m_shd_blk = '0;
    m_act_val = '0; m_act_en = '0; m_act_blk = '0;
    m_pend = 1'b0;
  endtask

  // Expected outputs follow directly from the edge count: slot position,
  // digit and blink phase are plain divisions of it.
  task automatic compare_model();
    int slot, dig, phase;
    logic vis;
    logic [3:0] nib, an;
    slot  = m_n % RD;
    dig   = (m_n / RD) % 4;
    phase = (m_n / (FRAME * BF)) % 2;
    nib   = 4'((m_act_val >> (4 * dig)) & 16'hF);
    vis   = (slot >= BC) && m_act_en[dig] && !(m_act_blk[dig] && phase == 1);
    an    = vis ? ~(4'b0001 << dig) : 4'b1111;
    chk("anode",   {12'h0, o_anode},   {12'h0, an});
    chk("en",      {15'h0, o_en},      {15'h0, vis});
    chk("binary",  {12'h0, o_binary},  {12'h0, nib});
    chk("pending", {15'h0, o_pending}, {15'h0, m_pend});
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] e, input logic [3:0] b);
    i_load = ld; i_value = v; i_digit_en = e; i_blink = b;
    @(posedge i_clk);
    if (i_rst) begin
      model_reset();
    end else begin
      m_n++;
      if (ld) begin
        m_shd_val = v; m_shd_en = e; m_shd_blk = b;
      end
      if (m_n % FRAME == 0) begin
        if (ld || m_pend) begin
          m_act_val = m_shd_val; m_act_en = m_shd_en; m_act_blk = m_shd_blk;
        end
        m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
    end
    #1;
    compare_model();
  endtask

  task automatic run_to(input int target);
    while (m_n < target) step(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0, 4'h0);
    chk("rst_anode",   {12'h0, o_anode},   16'h000F);
    chk("rst_en",      {15'h0, o_en},      16'h0000);
    chk("rst_binary",  {12'h0, o_binary},  16'h0000);
    chk("rst_pending", {15'h0, o_pending}, 16'h0000);
    i_rst = 1'b0;

    // Idle frame stays dark; load 4321 during slot 1
    run_to(9);
    step(1'b1, 16'h4321, 4'hF, 4'h0);
    chk("lit_pend_set", {15'h0, o_pending}, 16'h0001);
    run_to(31);
    chk("lit_prev_frame_dark", {12'h0, o_anode}, 16'h000F);
    run_to(32);
    chk("lit_pend_clr", {15'h0, o_pending}, 16'h0000);
    run_to(33);
    chk("lit_blank_anode", {12'h0, o_anode}, 16'h000F);
    chk("lit_blank_bin",   {12'h0, o_binary}, 16'h0001);
    run_to(34);
    chk("lit_d0_anode", {12'h0, o_anode}, 16'h000E);
    chk("lit_d0_bin",   {12'h0, o_binary}, 16'h0001);
    run_to(58);
    chk("lit_d3_anode", {12'h0, o_anode}, 16'h0007);
    chk("lit_d3_bin",   {12'h0, o_binary}, 16'h0004);

    // Two loads in one frame: last wins, pending held
    run_to(39);
    step(1'b1, 16'h1111, 4'hF, 4'h0);
    run_to(49);
    step(1'b1, 16'hABCD, 4'hF, 4'h0);
    chk("lit_pend_held", {15'h0, o_pending}, 16'h0001);
    run_to(66);
    chk("lit_abcd_d0", {12'h0, o_binary}, 16'h000D);

    // Load exactly on the boundary edge: immediate commit, no pending
    run_to(95);
    step(1'b1, 16'h00F0, 4'hF, 4'h0);
    chk("lit_bnd_no_pend", {15'h0, o_pending}, 16'h0000);
    run_to(106);
    chk("lit_bnd_d1_bin",   {12'h0, o_binary}, 16'h000F);
    chk("lit_bnd_d1_anode", {12'h0, o_anode},  16'h000D);

    // Enable/blink mix over several frames
    run_to(127);
    step(1'b1, 16'h0909, 4'b0101, 4'b0100);
    run_to(146);
    chk("lit_blink_on_d2", {12'h0, o_anode}, 16'h000B);
    run_to(210);
    chk("lit_blink_off_d2", {12'h0, o_anode}, 16'h000F);
    chk("lit_blink_off_en", {15'h0, o_en},    16'h0000);
    run_to(274);
    chk("lit_blink_back_d2", {12'h0, o_anode}, 16'h000B);

    // Asynchronous reset in slot 2 active window while pending
    run_to(339);
    step(1'b1, 16'h5555, 4'hF, 4'h0);
    run_to(342);
    #2 i_rst = 1'b1;
    #1;
    chk("lit_async_anode",   {12'h0, o_anode},   16'h000F);
    chk("lit_async_en",      {15'h0, o_en},      16'h0000);
    chk("lit_async_pending", {15'h0, o_pending}, 16'h0000);
    model_reset();
    step(1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0, 4'h0);
    i_rst = 1'b0;
    run_to(FRAME + 8);
    chk("lit_after_rst_dark", {12'h0, o_anode}, 16'h000F);

    // Randomized loads; some naturally land on boundary edges
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 11) == 0 || (m_n + 1) % FRAME == 0 && $urandom_range(0, 1) == 1)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
